// File: rtl/keypad_scanner_if.sv
// Keypad and consumer signal bundle for keypad_scanner: column drive, row sense and key handshake.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_drop;

  modport master (
    input  row,
    input  key_ready,
    output col,
    output key_code,
    output key_valid,
    output key_drop
  );

  modport slave (
    output row,
    output key_ready,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_drop
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and a valid/ready key output register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int COLS            = 4,
  parameter int ROWS            = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic        clk,
  input  logic        reset,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [VW-1:0] DIV_LAST = VW'(SCAN_DIV - 1);

  generate
    if (COLS != 4 || ROWS != 4 || SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("keypad_scanner: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      col_reg, col_next;
  logic [VW-1:0]   div_reg, div_next;
  logic [DW-1:0]   deb_reg, deb_next;
  logic [1:0]      cidx_reg, cidx_next;
  logic [1:0]      ridx_reg, ridx_next;
  logic [3:0]      code_reg, code_next;
  logic            valid_reg, valid_next;
  logic            drop_reg, drop_next;
  logic            load_req;
  logic            row_hit;
  logic [3:0]      col_rot;
  logic [3:0]      load_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0]   rep_reg, rep_next;
`endif

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign row_hit   = kp.row[ridx_reg];
  assign col_rot   = {col_reg[2:0], col_reg[3]};
  // Row r at the top of the pad maps to code group 3-r, which is simply ~r in two bits.
  assign load_code = {~ridx_reg, cidx_reg};

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    div_next   = div_reg;
    deb_next   = deb_reg;
    cidx_next  = cidx_reg;
    ridx_next  = ridx_reg;
    code_next  = code_reg;
    valid_next = valid_reg;
    drop_next  = drop_reg;
    load_req   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next   = rep_reg;
`endif

    case (state_reg)
      SCAN: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (kp.row == 4'b0000) begin
            col_next = col_rot;
          end else begin
            cidx_next  = onehot_idx(col_reg);
            ridx_next  = onehot_idx(kp.row);
            deb_next   = DW'(1);
            state_next = DEB_PRESS;
          end
        end else begin
          div_next = div_reg + VW'(1);
        end
      end
      DEB_PRESS: begin
        if (row_hit) begin
          if (deb_reg == DEB_MAX) begin
            load_req   = 1'b1;
            state_next = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_next   = '0;
`endif
          end else begin
            deb_next = deb_reg + DW'(1);
          end
        end else begin
          state_next = SCAN;
          col_next   = col_rot;
          div_next   = '0;
        end
      end
      HELD: begin
        if (!row_hit) begin
          state_next = DEB_REL;
          deb_next   = DW'(1);
`ifdef KEYPAD_REPEAT_EN
          rep_next   = '0;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_reg == REP_LAST) begin
          load_req = 1'b1;
          rep_next = '0;
        end else begin
          rep_next = rep_reg + RW'(1);
        end
`endif
      end
      DEB_REL: begin
        if (row_hit) begin
          state_next = HELD;
        end else if (deb_reg == DEB_MAX) begin
          state_next = SCAN;
          col_next   = col_rot;
          div_next   = '0;
        end else begin
          deb_next = deb_reg + DW'(1);
        end
      end
      default: state_next = SCAN;
    endcase

    // A load is allowed when the register is empty or being emptied this same cycle.
    if (load_req) begin
      if (!valid_reg || kp.key_ready) begin
        code_next  = load_code;
        valid_next = 1'b1;
      end else begin
        drop_next = 1'b1;
      end
    end else if (valid_reg && kp.key_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SCAN;
      col_reg   <= 4'b0001;
      div_reg   <= '0;
      deb_reg   <= '0;
      cidx_reg  <= '0;
      ridx_reg  <= '0;
      code_reg  <= '0;
      valid_reg <= 1'b0;
      drop_reg  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      div_reg   <= div_next;
      deb_reg   <= deb_next;
      cidx_reg  <= cidx_next;
      ridx_reg  <= ridx_next;
      code_reg  <= code_next;
      valid_reg <= valid_next;
      drop_reg  <= drop_next;
`ifdef KEYPAD_REPEAT_EN
      rep_reg   <= rep_next;
`endif
    end
  end

  assign kp.col       = col_reg;
  assign kp.key_code  = code_reg;
  assign kp.key_valid = valid_reg;
  assign kp.key_drop  = drop_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model closes the col->row loop, a monitor logs transfers.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       reset;
  logic       key_on;
  logic [3:0] key_idx;
  int         tests = 0;
  int         fails = 0;
  int         xfer  = 0;
  int         base;
  logic [3:0] codes[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kif.master)
  );

  always #5 clk = ~clk;

  // Key k sits in column k%4 and reports on row bit 3-k/4.
  assign kif.row = (key_on && kif.col[key_idx[1:0]]) ? (4'b1000 >> key_idx[3:2]) : 4'b0000;

  always @(posedge clk) begin
    if (!reset && kif.key_valid && kif.key_ready) begin
      xfer <= xfer + 1;
      codes.push_back(kif.key_code);
      $display("[TB] transfer code=%0d", kif.key_code);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] code_at(input int i);
    if (i < codes.size()) return codes[i];
    return 4'bxxxx;
  endfunction

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (kif.key_valid) break;
      tick(1);
    end
    check(tag, {31'd0, kif.key_valid}, 32'd1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] val, input int max);
    for (int i = 0; i < max; i++) begin
      if (kif.col == val) break;
      tick(1);
    end
    check(tag, {28'd0, kif.col}, {28'd0, val});
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    key_idx = k;
    key_on  = 1'b1;
    tick(hold);
    key_on  = 1'b0;
    tick(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col [5];
    exp_col = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset         = 1'b1;
    key_on        = 1'b0;
    key_idx       = 4'd0;
    kif.key_ready = 1'b1;
    tick(3);
    reset = 1'b0;

    // Idle scan after reset
    check("rst_valid", {31'd0, kif.key_valid}, 32'd0);
    check("rst_drop",  {31'd0, kif.key_drop},  32'd0);
    check("rst_code",  {28'd0, kif.key_code},  32'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("scan_col%0d", i), {28'd0, kif.col}, {28'd0, exp_col[i]});
      tick(2);
    end

    // Single press of key 6: one transfer, column frozen while held
    base    = xfer;
    key_idx = 4'd6;
    key_on  = 1'b1;
    wait_valid("k6_timeout", 40);
    check("k6_code", {28'd0, kif.key_code}, 32'd6);
    check("k6_col",  {28'd0, kif.col}, 32'b0100);
    tick(1);
    check("k6_valid_clear", {31'd0, kif.key_valid}, 32'd0);
    tick(25);
    check("k6_col_held", {28'd0, kif.col}, 32'b0100);
    key_on = 1'b0;
    tick(30);
    check("k6_count", xfer - base, 32'd1);
    check("k6_logged", {28'd0, code_at(base)}, 32'd6);

    // Corner keys 0 then 15
    base = xfer;
    press(4'd0, 40, 40);
    press(4'd15, 40, 40);
    check("k0k15_count", xfer - base, 32'd2);
    check("k0_code",  {28'd0, code_at(base)},     32'd0);
    check("k15_code", {28'd0, code_at(base + 1)}, 32'd15);

    // Key 9 glitches low during press debounce
    base = xfer;
    wait_col("k9_sync0", 4'b0001, 20);
    tick(1);
    wait_col("k9_sync1", 4'b0010, 20);
    key_idx = 4'd9;
    key_on  = 1'b1;
    tick(3);
    key_on  = 1'b0;
    tick(2);
    key_on  = 1'b1;
    check("k9_glitch_count", xfer - base, 32'd0);
    check("k9_glitch_valid", {31'd0, kif.key_valid}, 32'd0);
    tick(40);
    key_on = 1'b0;
    tick(40);
    check("k9_count", xfer - base, 32'd1);
    check("k9_code", {28'd0, code_at(base)}, 32'd9);

    // Consumer stalled: 3 is held, 12 is dropped
    kif.key_ready = 1'b0;
    base = xfer;
    press(4'd3, 40, 40);
    check("stall_valid", {31'd0, kif.key_valid}, 32'd1);
    check("stall_code3", {28'd0, kif.key_code}, 32'd3);
    check("stall_nodrop", {31'd0, kif.key_drop}, 32'd0);
    press(4'd12, 40, 40);
    check("drop_valid", {31'd0, kif.key_valid}, 32'd1);
    check("drop_code3", {28'd0, kif.key_code}, 32'd3);
    check("drop_set", {31'd0, kif.key_drop}, 32'd1);
    check("drop_count", xfer - base, 32'd0);
    kif.key_ready = 1'b1;
    tick(1);
    check("drain_valid", {31'd0, kif.key_valid}, 32'd0);
    check("drain_count", xfer - base, 32'd1);
    check("drain_code", {28'd0, code_at(base)}, 32'd3);
    tick(5);

    // Reset during press debounce of key 5
    wait_col("k5_sync0", 4'b0001, 20);
    tick(1);
    wait_col("k5_sync1", 4'b0010, 20);
    key_idx = 4'd5;
    key_on  = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("k5_rst_col", {28'd0, kif.col}, 32'b0001);
    check("k5_rst_valid", {31'd0, kif.key_valid}, 32'd0);
    check("k5_rst_drop", {31'd0, kif.key_drop}, 32'd0);
    tick(1);
    reset = 1'b0;
    base  = xfer;
    wait_valid("k5_timeout", 60);
    check("k5_code", {28'd0, kif.key_code}, 32'd5);
    tick(1);
    key_on = 1'b0;
    tick(40);
    check("k5_count", xfer - base, 32'd1);

    // Long hold of key 10: repeats only when auto-repeat is built in
    base    = xfer;
    key_idx = 4'd10;
    key_on  = 1'b1;
    wait_valid("k10_timeout", 40);
    tick(60);
    key_on = 1'b0;
    tick(40);
`ifdef KEYPAD_REPEAT_EN
    check("k10_count", xfer - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("k10_code%0d", i), {28'd0, code_at(base + i)}, 32'd10);
    end
`else
    check("k10_count", xfer - base, 32'd1);
    check("k10_code", {28'd0, code_at(base)}, 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
